// File: rtl/restoring_divider_pkg.sv
// Shared types for the restoring divider: FSM state encoding and default width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/restoring_divider_cla_sub.sv
// Combinational subtractor A - B = A + ~B + 1 built from 4-bit lookahead groups
// with the group carry rippling into the next group. Latency: 0 cycles.
// Backpressure: none (pure combinational slice).
//
// Ports:
//   i_a      minuend
//   i_b      subtrahend
//   o_diff   A - B modulo 2^WIDTH
//   o_borrow 1 when B > A (inverse of the adder carry out)
module cla_sub #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  localparam int NG = (WIDTH + 3) / 4;

  logic [WIDTH-1:0] w_bn;
  assign w_bn = ~i_b;

  genvar k;
  generate
    for (k = 0; k < NG; k++) begin : g_grp
      localparam int LO = 4 * k;
      // The top group is narrower whenever WIDTH is not a multiple of 4.
      localparam int GW = ((WIDTH - LO) < 4) ? (WIDTH - LO) : 4;

      logic          w_cin;
      logic          w_cout;
      logic [GW-1:0] w_g;
      logic [GW-1:0] w_p;
      logic [GW:0]   w_c;

      // The +1 of two's-complement negation enters as the carry into group 0.
      if (k == 0) begin : g_first
        assign w_cin = 1'b1;
      end else begin : g_rest
        assign w_cin = g_grp[k-1].w_cout;
      end

      assign w_g = i_a[LO +: GW] & w_bn[LO +: GW];
      assign w_p = i_a[LO +: GW] ^ w_bn[LO +: GW];

      // Every carry inside the group is a flat sum of products of the group's
      // g/p terms and the group carry-in, so no carry waits on another bit.
      always_comb begin
        logic v_gen;
        logic v_prop;
        v_gen  = 1'b0;
        v_prop = 1'b0;
        w_c    = '0;
        w_c[0] = w_cin;
        for (int i = 0; i < GW; i++) begin
          v_gen  = w_g[i];
          v_prop = w_p[i];
          for (int j = i - 1; j >= 0; j--) begin
            v_gen  = v_gen | (v_prop & w_g[j]);
            v_prop = v_prop & w_p[j];
          end
          w_c[i+1] = v_gen | (v_prop & w_cin);
        end
      end

      assign o_diff[LO +: GW] = w_p ^ w_c[GW-1:0];
      assign w_cout           = w_c[GW];
    end
  endgenerate

  assign o_borrow = ~g_grp[NG-1].w_cout;

endmodule

// File: rtl/restoring_divider.sv
// Unsigned restoring divider, one quotient bit per clock via a lookahead subtractor.
// Latency: WIDTH cycles from accept to out_valid (1 cycle for a zero divisor).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       operand handshake; dividend/divisor sampled on accept
//   out_valid/out_ready     result handshake
//   quotient/remainder      result, held after DONE until the next result loads
//   div_by_zero             result came from a zero divisor
module restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_t       r_state;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic [WIDTH:0]   w_rshift;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic [WIDTH:0]   w_r_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_last;
  logic             w_accept;
  logic             w_unused_rmsb;

  // Bring down the next dividend bit into the partial remainder.
  assign w_rshift = {r_r[WIDTH-1:0], r_q[WIDTH-1]};

  cla_sub #(
    .WIDTH (WIDTH + 1)
  ) u_sub (
    .i_a      (w_rshift),
    .i_b      ({1'b0, r_d}),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  // Restore on borrow: keep the shifted remainder instead of the difference.
  assign w_r_next = w_borrow ? w_rshift : w_diff;
  assign w_q_next = {r_q[WIDTH-2:0], ~w_borrow};
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_accept = in_valid && (r_state == IDLE);

  // After each step R < D, so the partial remainder MSB never feeds the result.
  assign w_unused_rmsb = r_r[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_d         <= '0;
      r_r         <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (divisor == '0) begin
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_d     <= divisor;
              r_r     <= '0;
              r_q     <= dividend;
              r_cnt   <= '0;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_r   <= w_r_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_r_next[WIDTH-1:0];
            r_dbz       <= 1'b0;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Handshake outputs are pure state decodes: no path from in_valid/out_ready.
  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider at WIDTH=8 and WIDTH=16.
// Latency: expected WIDTH cycles (1 for divide by zero).
// Backpressure: exercised by holding out_ready low in DONE.
module tb_restoring_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        in_valid8 = 1'b0, out_ready8 = 1'b0;
  logic        in_ready8, out_valid8, dbz8;
  logic [7:0]  dividend8 = '0, divisor8 = '0, quotient8, remainder8;

  logic        in_valid16 = 1'b0, out_ready16 = 1'b0;
  logic        in_ready16, out_valid16, dbz16;
  logic [15:0] dividend16 = '0, divisor16 = '0, quotient16, remainder16;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  restoring_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .dividend(dividend8), .divisor(divisor8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .quotient(quotient8), .remainder(remainder8), .div_by_zero(dbz8)
  );

  restoring_divider #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .dividend(dividend16), .divisor(divisor16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .quotient(quotient16), .remainder(remainder16), .div_by_zero(dbz16)
  );

  // Drive one operand pair into dut8; lat = edges after the accept edge until
  // out_valid is first seen (-1 if it never appears within the budget).
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready8 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    dividend8 = a; divisor8 = b; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid8) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic take8();
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready16 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    dividend16 = a; divisor16 = b; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (out_valid16) begin
        lat = i;
        break;
      end
    end
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({in_ready8, out_valid8, quotient8, remainder8, dbz8} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_hold: rdy=%b vld=%b q=%0d r=%0d z=%b, want rdy=1 vld=0 q=0 r=0 z=0",
               in_ready8, out_valid8, quotient8, remainder8, dbz8);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({in_ready16, out_valid16, quotient16, remainder16, dbz16} !== {1'b1, 1'b0, 16'd0, 16'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_idle16: rdy=%b vld=%b q=%0d r=%0d z=%b, want rdy=1 vld=0 q=0 r=0 z=0",
               in_ready16, out_valid16, quotient16, remainder16, dbz16);
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta [4] = '{8'd100, 8'd255, 8'd5,   8'd200};
    logic [7:0] tb [4] = '{8'd7,   8'd1,   8'd200, 8'd200};
    logic [7:0] eq [4] = '{8'd14,  8'd255, 8'd0,   8'd1};
    logic [7:0] er [4] = '{8'd2,   8'd0,   8'd5,   8'd0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue8(ta[i], tb[i], lat);
      vectors++;
      if (quotient8 !== eq[i] || remainder8 !== er[i] || dbz8 !== 1'b0 || lat != 8) begin
        miscompares++;
        $display("FAIL directed %0d/%0d: got q=%0d r=%0d z=%b lat=%0d, want q=%0d r=%0d z=0 lat=8",
                 ta[i], tb[i], quotient8, remainder8, dbz8, lat, eq[i], er[i]);
      end
      take8();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    issue8(8'd37, 8'd0, lat);
    vectors++;
    if (quotient8 !== 8'd255 || remainder8 !== 8'd37 || dbz8 !== 1'b1 || lat != 1) begin
      miscompares++;
      $display("FAIL div_zero: got q=%0d r=%0d z=%b lat=%0d, want q=255 r=37 z=1 lat=1",
               quotient8, remainder8, dbz8, lat);
    end
    take8();
    vectors++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || dbz8 !== 1'b1) begin
      miscompares++;
      $display("FAIL div_zero_hold: rdy=%b vld=%b z=%b, want rdy=1 vld=0 z=1",
               in_ready8, out_valid8, dbz8);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue8(8'd100, 8'd7, lat);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || quotient8 !== 8'd14 || remainder8 !== 8'd2) begin
        miscompares++;
        $display("FAIL stall_%0d: vld=%b rdy=%b q=%0d r=%0d, want vld=1 rdy=0 q=14 r=2",
                 i, out_valid8, in_ready8, quotient8, remainder8);
      end
    end
    out_ready8 = 1'b1;
    dividend8 = 8'd9; divisor8 = 8'd2; in_valid8 = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      miscompares++;
      $display("FAIL take_edge: rdy=%b vld=%b, want rdy=1 vld=0", in_ready8, out_valid8);
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0; out_ready8 = 1'b0;
    vectors++;
    if (in_ready8 !== 1'b0) begin
      miscompares++;
      $display("FAIL next_accept: rdy=%b, want 0", in_ready8);
    end
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid8) begin
        lat = i;
        break;
      end
    end
    vectors++;
    if (quotient8 !== 8'd4 || remainder8 !== 8'd1 || lat != 8) begin
      miscompares++;
      $display("FAIL b2b_result: q=%0d r=%0d lat=%0d, want q=4 r=1 lat=8", quotient8, remainder8, lat);
    end
    take8();
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    int seen;
    @(negedge clk);
    dividend8 = 8'd100; divisor8 = 8'd7; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready8, out_valid8, quotient8, remainder8, dbz8} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: rdy=%b vld=%b q=%0d r=%0d z=%b, want rdy=1 vld=0 q=0 r=0 z=0",
               in_ready8, out_valid8, quotient8, remainder8, dbz8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid8) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL no_partial: out_valid cycles=%0d, want 0", seen);
    end
    issue8(8'd9, 8'd2, lat);
    vectors++;
    if (quotient8 !== 8'd4 || remainder8 !== 8'd1 || dbz8 !== 1'b0 || lat != 8) begin
      miscompares++;
      $display("FAIL post_reset: q=%0d r=%0d z=%b lat=%0d, want q=4 r=1 z=0 lat=8",
               quotient8, remainder8, dbz8, lat);
    end
    take8();
  endtask

  task automatic test_sweep8(input int n);
    logic [7:0] a, b, mq, mr;
    logic mz;
    int lat, mlat;
    for (int k = 0; k < n; k++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      if (b == 0) begin mq = 8'hFF; mr = a; mz = 1'b1; mlat = 1; end
      else begin mq = a / b; mr = a % b; mz = 1'b0; mlat = 8; end
      issue8(a, b, lat);
      vectors++;
      if (quotient8 !== mq || remainder8 !== mr || dbz8 !== mz || lat != mlat) begin
        miscompares++;
        $display("FAIL sweep8 %0d/%0d: got q=%0d r=%0d z=%b lat=%0d, want q=%0d r=%0d z=%b lat=%0d",
                 a, b, quotient8, remainder8, dbz8, lat, mq, mr, mz, mlat);
      end
      take8();
    end
  endtask

  task automatic test_sweep16(input int n);
    logic [15:0] a, b, mq, mr;
    logic mz;
    int lat, mlat;
    for (int k = 0; k < n; k++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'($urandom_range(0, 15));
        1:       b = 16'($urandom_range(0, 255));
        default: b = 16'($urandom);
      endcase
      if (b == 0) begin mq = 16'hFFFF; mr = a; mz = 1'b1; mlat = 1; end
      else begin mq = a / b; mr = a % b; mz = 1'b0; mlat = 16; end
      issue16(a, b, lat);
      vectors++;
      if (quotient16 !== mq || remainder16 !== mr || dbz16 !== mz || lat != mlat) begin
        miscompares++;
        $display("FAIL sweep16 %0d/%0d: got q=%0d r=%0d z=%b lat=%0d, want q=%0d r=%0d z=%b lat=%0d",
                 a, b, quotient16, remainder16, dbz16, lat, mq, mr, mz, mlat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_calc();
    test_sweep8(1500);
    test_sweep16(800);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
